// File: rtl/yin_frame_sequencer.sv
// Sliding-window capture and run controller for min_tau_module: snapshots the newest
// FRAME_LEN samples every HOP samples, restarts the detector and latches its lag.

module yin_frame_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         snap_en,
  input  logic [W-1:0] shift_d,
  output logic [W-1:0] tap_q,
  output logic [W-1:0] snap_q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_q  <= '0;
      snap_q <= '0;
    end else begin
      if (shift_en) tap_q  <= shift_d;
      if (snap_en)  snap_q <= tap_q;
    end
  end
endmodule

module yin_frame_sequencer #(
  parameter int DATA_WIDTH       = 8,
  parameter int WINDOW_SIZE_BITS = 8,
  parameter int MAX_TAU          = 40,
  parameter int HOP              = 128,
  parameter int TIMEOUT_CYCLES   = 4096,
  localparam int FRAME_LEN       = (1 << WINDOW_SIZE_BITS) + MAX_TAU
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sample_valid,
  input  logic [DATA_WIDTH-1:0]           sample_in,
  output logic [FRAME_LEN*DATA_WIDTH-1:0] frame_data,
  output logic                            det_reset,
  input  logic                            det_ready,
  input  logic [7:0]                      min_tau_in,
  output logic [7:0]                      result_tau,
  output logic                            result_valid,
  output logic                            overrun,
  output logic                            timeout
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(FRAME_LEN);
  localparam logic [CW-1:0] HOP_MAX  = CW'(HOP);
  localparam logic [CW-1:0] HOP_PRE  = CW'(HOP - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_FILL = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] fill_cnt, hop_cnt;
  logic [TW-1:0] timer;
  logic          load_fire, run_first, ready_hit, timer_hit, busy;

  logic [FRAME_LEN-1:0][DATA_WIDTH-1:0] sr, snap;

  // Snapshot is taken on the edge that enters LOAD, so a sample arriving on that
  // same edge belongs to the next hop rather than this frame.
  assign load_fire = ((state == S_FILL) && (fill_cnt == FILL_MAX)) ||
                     ((state == S_WAIT) && (hop_cnt == HOP_MAX));

  genvar i;
  generate
    for (i = 0; i < FRAME_LEN; i++) begin : g_slot
      logic [DATA_WIDTH-1:0] d;
      if (i == FRAME_LEN - 1) begin : g_head
        assign d = sample_in;
      end else begin : g_body
        assign d = sr[i+1];
      end
      yin_frame_slot #(.W(DATA_WIDTH)) u_slot (
        .clk      (clk),
        .reset    (reset),
        .shift_en (sample_valid),
        .snap_en  (load_fire),
        .shift_d  (d),
        .tap_q    (sr[i]),
        .snap_q   (snap[i])
      );
    end
  endgenerate

  assign frame_data = snap;
  assign det_reset  = (state != S_RUN);

  // Timer is zero only in the first RUN cycle; a ready left over from the
  // previous frame must not complete the new one.
  assign run_first = (timer == '0);
  assign ready_hit = det_ready && !run_first;
  assign timer_hit = (timer == TO_LAST);
  assign busy      = (state == S_LOAD) || (state == S_RUN) || (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: if (fill_cnt == FILL_MAX) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_RUN;
      S_RUN: begin
        if (ready_hit)      state_nxt = S_DONE;
        else if (timer_hit) state_nxt = S_WAIT;
      end
      S_DONE: state_nxt = S_WAIT;
      S_WAIT: if (hop_cnt == HOP_MAX) state_nxt = S_LOAD;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FILL;
      fill_cnt <= '0;
      hop_cnt  <= '0;
      timer    <= '0;
    end else begin
      state <= state_nxt;
      if (sample_valid && (fill_cnt != FILL_MAX)) fill_cnt <= fill_cnt + 1'b1;
      if (load_fire)
        hop_cnt <= sample_valid ? CW'(1) : '0;
      else if (sample_valid && (hop_cnt != HOP_MAX))
        hop_cnt <= hop_cnt + 1'b1;
      if (state == S_LOAD)     timer <= '0;
      else if (state == S_RUN) timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_tau   <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (state == S_DONE) result_tau <= min_tau_in;
      result_valid <= (state == S_DONE);
      overrun      <= busy && sample_valid && (hop_cnt == HOP_PRE);
      timeout      <= (state == S_RUN) && !ready_hit && timer_hit;
    end
  end
endmodule

// File: tb/tb_yin_frame_sequencer.sv
// Directed bench for yin_frame_sequencer: first frame, result, overrun, timeout,
// stale-ready guard and mid-stream reset, with hand-computed expectations.

module tb_yin_frame_sequencer;
  localparam int DW = 8;
  localparam int FL = 296;

  logic            clk = 1'b0;
  logic            reset;
  logic            sample_valid;
  logic [DW-1:0]   sample_in;
  logic [FL*DW-1:0] frame_data;
  logic            det_reset;
  logic            det_ready;
  logic [7:0]      min_tau_in;
  logic [7:0]      result_tau;
  logic            result_valid;
  logic            overrun;
  logic            timeout;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int ov_n  = 0;
  int rv_n  = 0;
  int to_n  = 0;

  yin_frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .frame_data   (frame_data),
    .det_reset    (det_reset),
    .det_ready    (det_ready),
    .min_tau_in   (min_tau_in),
    .result_tau   (result_tau),
    .result_valid (result_valid),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] smp(input int i);
    return frame_data[i*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one accepted sample per cycle; value is the running index mod 256
  task automatic push();
    sample_valid = 1'b1;
    sample_in    = 8'(k);
    @(posedge clk);
    #1;
    k++;
    if (overrun)      ov_n++;
    if (result_valid) rv_n++;
    if (timeout)      to_n++;
  endtask

  task automatic push_to(input int last);
    while (k <= last) push();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; sample_valid = 1'b0; sample_in = '0;
    det_ready = 1'b0; min_tau_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame",   32'(|frame_data), 32'd0);
    chk("rst_detrst",  32'(det_reset),   32'd1);
    chk("rst_rv",      32'(result_valid), 32'd0);
    chk("rst_ovr",     32'(overrun),     32'd0);
    chk("rst_to",      32'(timeout),     32'd0);
    chk("rst_tau",     32'(result_tau),  32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // first frame: samples 0..295
    push_to(295);
    chk("fill_detrst", 32'(det_reset), 32'd1);
    chk("fill_frame",  32'(|frame_data), 32'd0);
    push_to(296);
    chk("f1_s0",      32'(smp(0)),   32'd0);
    chk("f1_s255",    32'(smp(255)), 32'd255);
    chk("f1_s295",    32'(smp(295)), 32'd39);
    chk("f1_load_dr", 32'(det_reset), 32'd1);
    push_to(297);
    chk("f1_run_dr",  32'(det_reset), 32'd0);

    // detector answers 50 cycles into RUN
    push_to(346);
    det_ready = 1'b1; min_tau_in = 8'd19;
    push_to(347);
    det_ready = 1'b0;
    chk("t3_done_dr", 32'(det_reset), 32'd1);
    chk("t3_rv_pre",  32'(result_valid), 32'd0);
    push_to(348);
    chk("t3_rv",      32'(result_valid), 32'd1);
    chk("t3_tau",     32'(result_tau), 32'd19);
    push_to(349);
    chk("t3_rv_drop", 32'(result_valid), 32'd0);
    chk("t3_rv_cnt",  32'(rv_n), 32'd1);
    push_to(423);
    chk("f2_pre_s0",  32'(smp(0)), 32'd0);
    push_to(424);
    chk("f2_s0",      32'(smp(0)),   32'd128);
    chk("f2_s295",    32'(smp(295)), 32'd167);
    chk("t3_no_ovr",  32'(ov_n), 32'd0);

    // detector answers 200 cycles into RUN: hop elapses first
    push_to(550);
    chk("t4_ovr_pre", 32'(overrun), 32'd0);
    push_to(551);
    chk("t4_ovr",     32'(overrun), 32'd1);
    push_to(552);
    chk("t4_ovr_end", 32'(overrun), 32'd0);
    push_to(624);
    det_ready = 1'b1; min_tau_in = 8'd23;
    push_to(625);
    det_ready = 1'b0;
    chk("t4_done_dr", 32'(det_reset), 32'd1);
    push_to(626);
    chk("t4_rv",      32'(result_valid), 32'd1);
    chk("t4_tau",     32'(result_tau), 32'd23);
    push_to(627);
    chk("f3_s0",      32'(smp(0)),   32'd75);
    chk("f3_s295",    32'(smp(295)), 32'd114);
    chk("f3_load_dr", 32'(det_reset), 32'd1);
    push_to(628);
    chk("f3_run_dr",  32'(det_reset), 32'd0);
    chk("t4_ovr_cnt", 32'(ov_n), 32'd1);
    chk("t4_rv_cnt",  32'(rv_n), 32'd2);

    // no answer: 4096 RUN cycles then abort
    push_to(4723);
    chk("t5_to_pre",  32'(timeout), 32'd0);
    chk("t5_run_dr",  32'(det_reset), 32'd0);
    push_to(4724);
    chk("t5_to",      32'(timeout), 32'd1);
    chk("t5_to_dr",   32'(det_reset), 32'd1);
    push_to(4725);
    chk("t5_to_end",  32'(timeout), 32'd0);
    chk("f4_s0",      32'(smp(0)),   32'd77);
    chk("f4_s295",    32'(smp(295)), 32'd116);
    chk("t5_to_cnt",  32'(to_n), 32'd1);
    chk("t5_rv_cnt",  32'(rv_n), 32'd2);
    chk("t5_ovr_cnt", 32'(ov_n), 32'd2);

    // ready stuck high from LOAD onward
    det_ready = 1'b1; min_tau_in = 8'd7;
    push_to(4726);
    chk("t6_run1_dr", 32'(det_reset), 32'd0);
    push_to(4727);
    chk("t6_stale",   32'(det_reset), 32'd0);
    push_to(4728);
    chk("t6_done_dr", 32'(det_reset), 32'd1);
    chk("t6_rv_pre",  32'(result_valid), 32'd0);
    det_ready = 1'b0;
    push_to(4729);
    chk("t6_rv",      32'(result_valid), 32'd1);
    chk("t6_tau",     32'(result_tau), 32'd7);

    // asynchronous reset mid-stream, then a fresh fill is required
    sample_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("t1_frame",   32'(|frame_data), 32'd0);
    chk("t1_tau",     32'(result_tau), 32'd0);
    chk("t1_detrst",  32'(det_reset), 32'd1);
    chk("t1_rv",      32'(result_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    k = 1000;
    push_to(1295);
    chk("t1_nofire",  32'(|frame_data), 32'd0);
    chk("t1_fill_dr", 32'(det_reset), 32'd1);
    push_to(1296);
    chk("t1_s0",      32'(smp(0)),   32'd232);
    chk("t1_s295",    32'(smp(295)), 32'd15);
    push_to(1297);
    chk("t1_run_dr",  32'(det_reset), 32'd0);
    sample_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
